// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - shared switch types: port count, packet type and arbiter state encodings.
package packet_pkg;

   localparam int NUM_PORTS  = 4;
   localparam int ADDR_WIDTH = 2;

   typedef enum logic [1:0] {
      SDP = 2'd0,
      MDP = 2'd1,
      BDP = 2'd2,
      ERR = 2'd3
   } p_type_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first unmasked request at or after base, with wrap.
module rr_pick
   import packet_pkg::*;
#(
   parameter int N = NUM_PORTS
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] base_i,
   input  logic [N-1:0]         mask_i,
   output logic [$clog2(N)-1:0] winner_o,
   output logic                 found_o
);

   localparam int IW = $clog2(N);

   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   always_comb begin
      winner_o = '0;
      found_o  = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int i = 0; i < N; i++) begin
         // base_i is always < N, so one conditional subtract is enough for the wrap
         sum = {1'b0, base_i} + (IW+1)'(i);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         idx = sum[IW-1:0];
         if (!found_o && req_i[idx] && !mask_i[idx]) begin
            found_o  = 1'b1;
            winner_o = idx;
         end
      end
   end

endmodule

// File: rtl/port_arbiter.sv
// rtl/port_arbiter.sv - per-egress round-robin packet arbiter with zero-bubble handover.
// Optional owner-stall timeout enabled by defining ARB_TIMEOUT_EN.
module port_arbiter
   import packet_pkg::*;
#(
   parameter int NUM_PORTS      = packet_pkg::NUM_PORTS,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_PORTS-1:0]         req,
   input  logic [NUM_PORTS-1:0]         last,
   input  logic                         out_ready,
   output logic [NUM_PORTS-1:0]         gnt,
   output logic                         gnt_valid,
   output logic [$clog2(NUM_PORTS)-1:0] owner,
   output logic                         xfer,
   output logic                         timeout_err
);

   localparam int IW = $clog2(NUM_PORTS);
   localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);

   arb_state_t           state_q, state_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]        owner_q, owner_d;
   logic [NUM_PORTS-1:0] gnt_q, gnt_d;

   logic [IW-1:0]        ptr_next;
   logic [IW-1:0]        pick_base;
   logic [NUM_PORTS-1:0] pick_mask;
   logic [IW-1:0]        winner;
   logic                 found;
   logic                 rel_last;
   logic                 rel_now;
   logic                 timeout_hit;

   assign xfer      = gnt_valid & req[owner_q] & out_ready;
   assign rel_last  = (state_q == LOCKED) & xfer & last[owner_q];
   assign rel_now   = rel_last | timeout_hit;
   assign ptr_next  = (owner_q == IW'(NUM_PORTS-1)) ? '0 : owner_q + 1'b1;

   // The same picker serves IDLE arbitration and the same-cycle handover,
   // where the departing owner is masked so it cannot win back immediately.
   assign pick_base = (state_q == LOCKED) ? ptr_next : rr_ptr_q;
   assign pick_mask = (state_q == LOCKED) ? (ONE_HOT0 << owner_q) : '0;

   rr_pick #(
      .N (NUM_PORTS)
   ) u_rr_pick (
      .req_i    (req),
      .base_i   (pick_base),
      .mask_i   (pick_mask),
      .winner_o (winner),
      .found_o  (found)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES+1);

   logic [CW-1:0] stall_q, stall_d;
   logic          timeout_err_q;

   always_comb begin
      stall_d     = '0;
      timeout_hit = 1'b0;
      if (state_q == LOCKED && !req[owner_q]) begin
         if (stall_q == CW'(TIMEOUT_CYCLES-1)) begin
            timeout_hit = 1'b1;
         end else begin
            stall_d = stall_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q       <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         stall_q       <= stall_d;
         timeout_err_q <= timeout_hit;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout_hit        = 1'b0;
   assign timeout_err        = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      gnt_d    = gnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = LOCKED;
               owner_d = winner;
               gnt_d   = ONE_HOT0 << winner;
            end
         end
         LOCKED: begin
            if (rel_now) begin
               rr_ptr_d = ptr_next;
               if (found) begin
                  owner_d = winner;
                  gnt_d   = ONE_HOT0 << winner;
               end else begin
                  state_d = IDLE;
                  owner_d = '0;
                  gnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = '0;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         gnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         gnt_q    <= gnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = (state_q == LOCKED);
   assign owner     = owner_q;

endmodule

// File: tb/tb_port_arbiter.sv
// tb/tb_port_arbiter.sv - scoreboard bench for port_arbiter with reactive ingress beat counters.
module tb_port_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] last;
   logic       out_ready;
   logic [3:0] gnt;
   logic       gnt_valid;
   logic [1:0] owner;
   logic       xfer;
   logic       timeout_err;

   typedef struct packed {
      logic [3:0] req;
      logic       rdy;
      logic       xfer;
      logic [3:0] gnt;
      logic [1:0] own;
      logic       terr;
   } exp_t;

   exp_t sb_q[$];
   int   len[4];
   int   cnt[4];
   int   n_cmp;
   int   n_err;

   port_arbiter #(
      .NUM_PORTS      (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .last        (last),
      .out_ready   (out_ready),
      .gnt         (gnt),
      .gnt_valid   (gnt_valid),
      .owner       (owner),
      .xfer        (xfer),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected owner is derived here from the expected grant, never from the DUT.
   function automatic void push(input logic [3:0] r, input logic rdy, input logic x,
                                input logic [3:0] g, input logic te);
      exp_t e;
      e.req  = r;
      e.rdy  = rdy;
      e.xfer = x;
      e.gnt  = g;
      e.terr = te;
      e.own  = 2'd0;
      for (int p = 0; p < 4; p++) if (g[p]) e.own = 2'(p);
      sb_q.push_back(e);
   endfunction

   // One cycle of stimulus: ingress ports raise last on their final beat and
   // advance their beat counters when their granted beat actually moved.
   task automatic tick(input logic [3:0] r, input logic rdy, output logic x_pre);
      logic [3:0] g_pre;
      req       = r;
      out_ready = rdy;
      for (int p = 0; p < 4; p++) last[p] = r[p] && (cnt[p] == len[p] - 1);
      #1;
      x_pre = xfer;
      g_pre = gnt;
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) begin
         if (g_pre[p] && x_pre) cnt[p] = last[p] ? 0 : cnt[p] + 1;
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req       = '0;
      last      = '0;
      out_ready = 1'b1;
      for (int p = 0; p < 4; p++) cnt[p] = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({gnt, gnt_valid, owner, timeout_err, xfer} !== 9'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got gnt=%b gv=%b own=%0d te=%b xfer=%b want all zero",
                  gnt, gnt_valid, owner, timeout_err, xfer);
      end
      req = 4'b1111;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({gnt, gnt_valid} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_held: got gnt=%b gv=%b want 0000/0", gnt, gnt_valid);
      end
      rst = 1'b0;
      req = '0;
   endtask

   task automatic test_two_ports();
      exp_t e;
      logic x;
      do_reset();
      for (int p = 0; p < 4; p++) len[p] = 3;
      push(4'b0101, 1, 0, 4'b0001, 0);
      push(4'b0101, 1, 1, 4'b0001, 0);
      push(4'b0101, 1, 1, 4'b0001, 0);
      push(4'b0101, 1, 1, 4'b0100, 0);
      push(4'b0101, 1, 1, 4'b0100, 0);
      push(4'b0101, 1, 1, 4'b0100, 0);
      push(4'b0101, 1, 1, 4'b0001, 0);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         tick(e.req, e.rdy, x);
         n_cmp++;
         if (x !== e.xfer) begin
            n_err++; $display("FAIL two_ports_xfer: got %b want %b", x, e.xfer);
         end
         n_cmp++;
         if ({gnt_valid, owner, gnt} !== {|e.gnt, e.own, e.gnt}) begin
            n_err++;
            $display("FAIL two_ports_gnt: got gnt=%b gv=%b own=%0d want gnt=%b own=%0d",
                     gnt, gnt_valid, owner, e.gnt, e.own);
         end
      end
   endtask

   task automatic test_rotation();
      exp_t e;
      logic x;
      do_reset();
      for (int p = 0; p < 4; p++) len[p] = 1;
      push(4'b1111, 1, 0, 4'b0001, 0);
      push(4'b1111, 1, 1, 4'b0010, 0);
      push(4'b1111, 1, 1, 4'b0100, 0);
      push(4'b1111, 1, 1, 4'b1000, 0);
      push(4'b1111, 1, 1, 4'b0001, 0);
      push(4'b1111, 1, 1, 4'b0010, 0);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         tick(e.req, e.rdy, x);
         n_cmp++;
         if (x !== e.xfer) begin
            n_err++; $display("FAIL rotation_xfer: got %b want %b", x, e.xfer);
         end
         n_cmp++;
         if ({gnt_valid, owner, gnt} !== {|e.gnt, e.own, e.gnt}) begin
            n_err++;
            $display("FAIL rotation_gnt: got gnt=%b gv=%b own=%0d want gnt=%b own=%0d",
                     gnt, gnt_valid, owner, e.gnt, e.own);
         end
         n_cmp++;
         if ($countones(gnt) > 1) begin
            n_err++; $display("FAIL rotation_onehot: got gnt=%b want at most one bit", gnt);
         end
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      logic x;
      do_reset();
      for (int p = 0; p < 4; p++) len[p] = 3;
      push(4'b0100, 1, 0, 4'b0100, 0);
      push(4'b1110, 1, 1, 4'b0100, 0);
      for (int i = 0; i < 5; i++) push(4'b1110, 0, 0, 4'b0100, 0);
      push(4'b1110, 1, 1, 4'b0100, 0);
      push(4'b1110, 1, 1, 4'b1000, 0);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         tick(e.req, e.rdy, x);
         n_cmp++;
         if (x !== e.xfer) begin
            n_err++; $display("FAIL backpressure_xfer: got %b want %b", x, e.xfer);
         end
         n_cmp++;
         if ({gnt_valid, owner, gnt} !== {|e.gnt, e.own, e.gnt}) begin
            n_err++;
            $display("FAIL backpressure_gnt: got gnt=%b gv=%b own=%0d want gnt=%b own=%0d",
                     gnt, gnt_valid, owner, e.gnt, e.own);
         end
      end
   endtask

   task automatic test_self_rerequest();
      exp_t e;
      logic x;
      do_reset();
      for (int p = 0; p < 4; p++) len[p] = 2;
      push(4'b1000, 1, 0, 4'b1000, 0);
      push(4'b1000, 1, 1, 4'b1000, 0);
      push(4'b1000, 1, 1, 4'b0000, 0);
      push(4'b1000, 1, 0, 4'b1000, 0);
      push(4'b1000, 1, 1, 4'b1000, 0);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         tick(e.req, e.rdy, x);
         n_cmp++;
         if (x !== e.xfer) begin
            n_err++; $display("FAIL self_rereq_xfer: got %b want %b", x, e.xfer);
         end
         n_cmp++;
         if ({gnt_valid, owner, gnt} !== {|e.gnt, e.own, e.gnt}) begin
            n_err++;
            $display("FAIL self_rereq_gnt: got gnt=%b gv=%b own=%0d want gnt=%b own=%0d",
                     gnt, gnt_valid, owner, e.gnt, e.own);
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      exp_t e;
      logic x;
      do_reset();
      for (int p = 0; p < 4; p++) len[p] = 3;
      push(4'b0010, 1, 0, 4'b0010, 0);
      push(4'b0010, 1, 1, 4'b0010, 0);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         tick(e.req, e.rdy, x);
         n_cmp++;
         if ({gnt_valid, owner, gnt} !== {|e.gnt, e.own, e.gnt}) begin
            n_err++;
            $display("FAIL rst_mid_pre_gnt: got gnt=%b own=%0d want gnt=%b own=%0d",
                     gnt, owner, e.gnt, e.own);
         end
      end
      #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({gnt, gnt_valid, owner} !== 7'b0) begin
         n_err++;
         $display("FAIL rst_mid_async: got gnt=%b gv=%b own=%0d want 0000/0/0", gnt, gnt_valid, owner);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int p = 0; p < 4; p++) cnt[p] = 0;
      push(4'b0011, 1, 0, 4'b0001, 0);
      push(4'b0011, 1, 1, 4'b0001, 0);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         tick(e.req, e.rdy, x);
         n_cmp++;
         if ({gnt_valid, owner, gnt} !== {|e.gnt, e.own, e.gnt}) begin
            n_err++;
            $display("FAIL rst_mid_regrant: got gnt=%b own=%0d want gnt=%b own=%0d",
                     gnt, owner, e.gnt, e.own);
         end
      end
   endtask

   task automatic test_owner_stall();
      exp_t e;
      logic x;
      do_reset();
      for (int p = 0; p < 4; p++) len[p] = 5;
      push(4'b0010, 1, 0, 4'b0010, 0);
      push(4'b0010, 1, 1, 4'b0010, 0);
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 15; i++) push(4'b0100, 1, 0, 4'b0010, 0);
      push(4'b0100, 1, 0, 4'b0100, 1);
      push(4'b0100, 1, 1, 4'b0100, 0);
`else
      for (int i = 0; i < 20; i++) push(4'b0100, 1, 0, 4'b0010, 0);
`endif
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         tick(e.req, e.rdy, x);
         n_cmp++;
         if (x !== e.xfer) begin
            n_err++; $display("FAIL stall_xfer: got %b want %b", x, e.xfer);
         end
         n_cmp++;
         if ({gnt_valid, owner, gnt} !== {|e.gnt, e.own, e.gnt}) begin
            n_err++;
            $display("FAIL stall_gnt: got gnt=%b gv=%b own=%0d want gnt=%b own=%0d",
                     gnt, gnt_valid, owner, e.gnt, e.own);
         end
         n_cmp++;
         if (timeout_err !== e.terr) begin
            n_err++; $display("FAIL stall_timeout_err: got %b want %b", timeout_err, e.terr);
         end
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b0;
      req       = '0;
      last      = '0;
      out_ready = 1'b1;
      for (int p = 0; p < 4; p++) begin
         len[p] = 1;
         cnt[p] = 0;
      end
      #1;
      rst = 1'b1;
      test_reset();
      test_two_ports();
      test_rotation();
      test_backpressure();
      test_self_rerequest();
      test_reset_mid_packet();
      test_owner_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
